// File: rtl/kda_pkg.sv
// Shared types and defaults for the PBKDF2 job scheduler.
package kda_pkg;

  localparam int unsigned BlkWDefault     = 8;
  localparam int unsigned NumCoresDefault = 4;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/kda_job_sched_if.sv
// Job/core/result handshake bundle for kda_job_sched; master drives jobs, core status and yumi.
interface kda_job_sched_if
  import kda_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDefault,
  parameter int unsigned BLK_W     = BlkWDefault,
  localparam int unsigned IdxW     = $clog2(NUM_CORES)
);

  logic                       job_v;
  logic [BLK_W-1:0]           job_blocks;
  logic                       job_ready;
  logic [NUM_CORES-1:0]       core_v;
  logic [NUM_CORES*BLK_W-1:0] core_blk;
  logic [NUM_CORES-1:0]       core_ready;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0]       core_ack;
  logic                       res_v;
  logic [IdxW-1:0]            res_core;
  logic [BLK_W-1:0]           res_blk;
  logic                       res_last;
  logic                       res_yumi;

  modport master (
    output job_v, job_blocks, core_ready, core_done, res_yumi,
    input  job_ready, core_v, core_blk, core_ack, res_v, res_core, res_blk, res_last
  );

  modport slave (
    input  job_v, job_blocks, core_ready, core_done, res_yumi,
    output job_ready, core_v, core_blk, core_ack, res_v, res_core, res_blk, res_last
  );

endinterface

// File: rtl/kda_core_pick.sv
// Priority encoder: lowest set bit of mask as one-hot and binary index, plus any-set flag.
module kda_core_pick
  import kda_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDefault,
  localparam int unsigned IdxW     = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] mask,
  output logic [NUM_CORES-1:0] onehot,
  output logic [IdxW-1:0]      idx,
  output logic                 any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    // Scan high to low so the lowest set bit is written last and wins.
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (mask[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IdxW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kda_job_sched.sv
// Dispatches N derived-key blocks across PBKDF2 cores and returns results in block order.
// Optional KDA_SCHED_PERF_EN adds a saturating busy_cycles_o counter of cycles spent in RUN.
module kda_job_sched
  import kda_pkg::*;
#(
  parameter int unsigned NUM_CORES = NumCoresDefault,
  parameter int unsigned BLK_W     = BlkWDefault,
  localparam int unsigned IdxW     = $clog2(NUM_CORES)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       job_v_i,
  input  logic [BLK_W-1:0]           job_blocks_i,
  output logic                       job_ready_o,
  output logic [NUM_CORES-1:0]       core_v_o,
  output logic [NUM_CORES*BLK_W-1:0] core_blk_o,
  input  logic [NUM_CORES-1:0]       core_ready_i,
  input  logic [NUM_CORES-1:0]       core_done_i,
  output logic [NUM_CORES-1:0]       core_ack_o,
  output logic                       res_v_o,
  output logic [IdxW-1:0]            res_core_o,
  output logic [BLK_W-1:0]           res_blk_o,
  output logic                       res_last_o,
  input  logic                       res_yumi_i
`ifdef KDA_SCHED_PERF_EN
  ,
  output logic [31:0]                busy_cycles_o
`endif
);

  // One extra bit so next_disp can step past a full-range N.
  localparam int unsigned CntW = BLK_W + 1;

  state_e                         state_q, state_d;
  logic [CntW-1:0]                n_q, n_d;
  logic [CntW-1:0]                disp_q, disp_d;
  logic [CntW-1:0]                res_q, res_d;
  logic [NUM_CORES-1:0]           busy_q, busy_d;
  logic [NUM_CORES-1:0][BLK_W-1:0] blk_q, blk_d;
  logic                           lock_q, lock_d;
  logic [IdxW-1:0]                lock_idx_q, lock_idx_d;

  logic [NUM_CORES-1:0] free_mask;
  logic [NUM_CORES-1:0] pick_onehot;
  logic [IdxW-1:0]      pick_idx;
  logic                 pick_any;

  logic                 disp_v;
  logic [IdxW-1:0]      disp_idx;
  logic                 disp_fire;
  logic                 res_hit;
  logic [IdxW-1:0]      hit_idx;
  logic                 consume;

  assign free_mask = ~busy_q;

  kda_core_pick #(
    .NUM_CORES(NUM_CORES)
  ) u_core_pick (
    .mask  (free_mask),
    .onehot(pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    // An offer that has not yet been accepted stays pinned to its core.
    disp_v    = (state_q == StRun) && (disp_q <= n_q) && (lock_q || pick_any);
    disp_idx  = lock_q ? lock_idx_q : pick_idx;
    disp_fire = disp_v && core_ready_i[disp_idx];

    core_v_o   = '0;
    core_blk_o = '0;
    if (disp_v) begin
      core_v_o = lock_q ? (NUM_CORES'(1) << lock_idx_q) : pick_onehot;
      core_blk_o[disp_idx*BLK_W +: BLK_W] = disp_q[BLK_W-1:0];
    end

    res_hit = 1'b0;
    hit_idx = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (busy_q[c] && (blk_q[c] == res_q[BLK_W-1:0])) begin
        res_hit = 1'b1;
        hit_idx = IdxW'(c);
      end
    end

    res_v_o     = (state_q == StRun) && res_hit && core_done_i[hit_idx];
    res_core_o  = res_v_o ? hit_idx : '0;
    res_blk_o   = res_v_o ? res_q[BLK_W-1:0] : '0;
    res_last_o  = res_v_o && (res_q == n_q);
    consume     = res_v_o && res_yumi_i;
    core_ack_o  = consume ? (NUM_CORES'(1) << hit_idx) : '0;
    job_ready_o = (state_q == StIdle);
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    disp_d     = disp_q;
    res_d      = res_q;
    busy_d     = busy_q;
    blk_d      = blk_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;

    unique case (state_q)
      StIdle: begin
        if (job_v_i) begin
          n_d     = (job_blocks_i == '0) ? CntW'(1) : {1'b0, job_blocks_i};
          disp_d  = CntW'(1);
          res_d   = CntW'(1);
          lock_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (disp_fire) begin
          busy_d[disp_idx] = 1'b1;
          blk_d[disp_idx]  = disp_q[BLK_W-1:0];
          disp_d           = disp_q + CntW'(1);
          lock_d           = 1'b0;
        end else if (disp_v) begin
          lock_d     = 1'b1;
          lock_idx_d = disp_idx;
        end
        // The dispatched core is free and the consumed one busy, so they never collide.
        if (consume) begin
          busy_d[hit_idx] = 1'b0;
          res_d           = res_q + CntW'(1);
          if (res_q == n_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      n_q        <= '0;
      disp_q     <= '0;
      res_q      <= '0;
      busy_q     <= '0;
      blk_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      disp_q     <= disp_d;
      res_q      <= res_d;
      busy_q     <= busy_d;
      blk_q      <= blk_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

`ifdef KDA_SCHED_PERF_EN
  logic [31:0] busy_cyc_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_cyc_q <= '0;
    end else if ((state_q == StIdle) && job_v_i) begin
      busy_cyc_q <= '0;
    end else if ((state_q == StRun) && (busy_cyc_q != '1)) begin
      busy_cyc_q <= busy_cyc_q + 32'd1;
    end
  end

  assign busy_cycles_o = busy_cyc_q;
`endif

endmodule

// File: tb/tb_kda_job_sched.sv
// Directed bench for kda_job_sched: block-order model compared every cycle plus literal pins.
module tb_kda_job_sched;
  import kda_pkg::*;

  localparam int NC = 4;
  localparam int BW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kda_job_sched_if #(.NUM_CORES(NC), .BLK_W(BW)) bus ();

`ifdef KDA_SCHED_PERF_EN
  logic [31:0] busy_cycles;
`endif

  kda_job_sched #(
    .NUM_CORES(NC),
    .BLK_W    (BW)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .job_v_i     (bus.job_v),
    .job_blocks_i(bus.job_blocks),
    .job_ready_o (bus.job_ready),
    .core_v_o    (bus.core_v),
    .core_blk_o  (bus.core_blk),
    .core_ready_i(bus.core_ready),
    .core_done_i (bus.core_done),
    .core_ack_o  (bus.core_ack),
    .res_v_o     (bus.res_v),
    .res_core_o  (bus.res_core),
    .res_blk_o   (bus.res_blk),
    .res_last_o  (bus.res_last),
    .res_yumi_i  (bus.res_yumi)
`ifdef KDA_SCHED_PERF_EN
    ,
    .busy_cycles_o(busy_cycles)
`endif
  );

  // Core stand-ins: done appears lat[c] cycles after start and holds until acked.
  logic [NC-1:0] run;
  int cnt [NC];
  int lat [NC];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run <= '0;
      for (int c = 0; c < NC; c++) cnt[c] <= 0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        if (bus.core_ack[c]) run[c] <= 1'b0;
        else if (bus.core_v[c] && bus.core_ready[c]) begin
          run[c] <= 1'b1;
          cnt[c] <= lat[c];
        end else if (run[c] && cnt[c] > 0) cnt[c] <= cnt[c] - 1;
      end
    end
  end

  always_comb begin
    bus.core_done = '0;
    for (int c = 0; c < NC; c++) bus.core_done[c] = run[c] && (cnt[c] == 0);
  end

  // Event log of observed handshakes for literal pins.
  typedef struct {
    int blk;
    int core;
    int cyc;
    bit last;
  } ev_t;
  ev_t disp_log[$];
  ev_t res_log[$];
  int  ack_cnt [NC];
  int  cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < NC; c++) begin
      if (bus.core_v[c] && bus.core_ready[c])
        disp_log.push_back('{int'(bus.core_blk[c*BW +: BW]), c, cyc, 1'b0});
      if (bus.core_ack[c]) ack_cnt[c] <= ack_cnt[c] + 1;
    end
    if (bus.res_v && bus.res_yumi)
      res_log.push_back('{int'(bus.res_blk), int'(bus.res_core), cyc, bus.res_last});
  end

  // Behavioural model: in-flight blocks keyed by block number, value = core holding it.
  bit     m_run;
  int     m_n, m_nd, m_nr;
  bit     m_lock;
  int     m_lock_idx;
  longint m_cycles;
  int     inflight[int];

  typedef struct packed {
    logic              job_ready;
    logic [NC-1:0]     core_v;
    logic [NC*BW-1:0]  core_blk;
    logic              res_v;
    logic [IW-1:0]     res_core;
    logic [BW-1:0]     res_blk;
    logic              res_last;
    logic [NC-1:0]     ack;
  } exp_t;

  function automatic bit core_taken(int c);
    foreach (inflight[k]) if (inflight[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int offer_core();
    if (!m_run || m_nd > m_n) return -1;
    if (m_lock) return m_lock_idx;
    for (int c = 0; c < NC; c++) if (!core_taken(c)) return c;
    return -1;
  endfunction

  function automatic int result_core();
    if (!m_run || !inflight.exists(m_nr)) return -1;
    if (!bus.core_done[inflight[m_nr]]) return -1;
    return inflight[m_nr];
  endfunction

  function automatic exp_t calc();
    exp_t e;
    int   off, rc;
    e = '0;
    e.job_ready = !m_run;
    off = offer_core();
    rc  = result_core();
    if (off >= 0) begin
      e.core_v[off] = 1'b1;
      e.core_blk[off*BW +: BW] = BW'(m_nd);
    end
    if (rc >= 0) begin
      e.res_v    = 1'b1;
      e.res_core = IW'(rc);
      e.res_blk  = BW'(m_nr);
      e.res_last = (m_nr == m_n);
      if (bus.res_yumi) e.ack[rc] = 1'b1;
    end
    return e;
  endfunction

  task automatic model_reset();
    m_run = 0; m_n = 0; m_nd = 0; m_nr = 0; m_lock = 0; m_lock_idx = 0; m_cycles = 0;
    inflight.delete();
  endtask

  task automatic model_step();
    int off, rc;
    if (!m_run) begin
      if (bus.job_v) begin
        m_n = (bus.job_blocks == 0) ? 1 : int'(bus.job_blocks);
        m_nd = 1; m_nr = 1; m_run = 1; m_lock = 0; m_cycles = 0;
      end
      return;
    end
    if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
    off = offer_core();
    rc  = result_core();
    if (off >= 0) begin
      if (bus.core_ready[off]) begin
        inflight[m_nd] = off; m_nd++; m_lock = 0;
      end else begin
        m_lock = 1; m_lock_idx = off;
      end
    end
    if (rc >= 0 && bus.res_yumi) begin
      inflight.delete(m_nr);
      if (m_nr == m_n) m_run = 0;
      m_nr++;
    end
  endtask

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic compare_all();
    exp_t e;
    e = calc();
    chk("job_ready", 64'(bus.job_ready), 64'(e.job_ready));
    chk("core_v", 64'(bus.core_v), 64'(e.core_v));
    chk("core_blk", 64'(bus.core_blk), 64'(e.core_blk));
    chk("res_v", 64'(bus.res_v), 64'(e.res_v));
    chk("res_core", 64'(bus.res_core), 64'(e.res_core));
    chk("res_blk", 64'(bus.res_blk), 64'(e.res_blk));
    chk("res_last", 64'(bus.res_last), 64'(e.res_last));
    chk("core_ack", 64'(bus.core_ack), 64'(e.ack));
`ifdef KDA_SCHED_PERF_EN
    chk("busy_cycles", 64'(busy_cycles), 64'(m_cycles));
`endif
  endtask

  // One cycle: compare on the falling edge, step the model on the rising edge, then drive.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic start_job(input int n);
    bus.job_v = 1'b1;
    bus.job_blocks = BW'(n);
    tick();
    bus.job_v = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (!bus.job_ready && k < budget) begin
      tick();
      k++;
    end
    chk(name, 64'(bus.job_ready), 64'd1);
  endtask

  int base_d, base_r;
  int ack_base[NC];

  initial begin
    model_reset();
    bus.job_v = 1'b0;
    bus.job_blocks = '0;
    bus.core_ready = '1;
    bus.res_yumi = 1'b1;
    for (int c = 0; c < NC; c++) lat[c] = 0;
    repeat (3) tick();
    chk("rst_job_ready", 64'(bus.job_ready), 64'd1);
    chk("rst_core_v", 64'(bus.core_v), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single block.
    start_job(1);
    chk("n1_core_v", 64'(bus.core_v), 64'h1);
    chk("n1_core_blk", 64'(bus.core_blk), 64'h1);
    wait_idle("n1_idle", 20);
    chk("n1_res_blk", 64'(res_log[$].blk), 64'd1);
    chk("n1_res_last", 64'(res_log[$].last), 64'd1);

    // Four blocks finishing in reverse core order.
    lat[0] = 8; lat[1] = 6; lat[2] = 4; lat[3] = 2;
    base_r = res_log.size();
    for (int c = 0; c < NC; c++) ack_base[c] = ack_cnt[c];
    start_job(4);
    wait_idle("n4_idle", 60);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("n4_blk%0d", i), 64'(res_log[base_r+i].blk), 64'(i + 1));
      chk($sformatf("n4_core%0d", i), 64'(res_log[base_r+i].core), 64'(i));
      chk($sformatf("n4_ack%0d", i), 64'(ack_cnt[i] - ack_base[i]), 64'd1);
    end
    chk("n4_last", 64'(res_log[base_r+3].last), 64'd1);

    // More blocks than cores: 5 and 6 reuse cores 0 and 1.
    for (int c = 0; c < NC; c++) lat[c] = 3;
    base_d = disp_log.size();
    base_r = res_log.size();
    start_job(6);
    wait_idle("n6_idle", 80);
    chk("n6_disp5_core", 64'(disp_log[base_d+4].core), 64'd0);
    chk("n6_disp5_blk", 64'(disp_log[base_d+4].blk), 64'd5);
    chk("n6_disp6_core", 64'(disp_log[base_d+5].core), 64'd1);
    chk("n6_disp6_blk", 64'(disp_log[base_d+5].blk), 64'd6);
    chk("n6_disp5_after", 64'(disp_log[base_d+4].cyc > res_log[base_r].cyc), 64'd1);
    chk("n6_disp6_after", 64'(disp_log[base_d+5].cyc > res_log[base_r+1].cyc), 64'd1);

    // Core 0 stalls its ready: offer must hold and nothing else starts.
    for (int c = 0; c < NC; c++) lat[c] = 0;
    bus.core_ready = 4'b1110;
    base_d = disp_log.size();
    start_job(2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_core_v", 64'(bus.core_v), 64'h1);
      chk("stall_core_blk", 64'(bus.core_blk), 64'h1);
    end
    chk("stall_no_disp", 64'(disp_log.size() - base_d), 64'd0);
    bus.core_ready = '1;
    wait_idle("stall_idle", 30);

    // Downstream back-pressure; a job request in RUN is ignored.
    bus.res_yumi = 1'b0;
    for (int c = 0; c < NC; c++) ack_base[c] = ack_cnt[c];
    start_job(1);
    repeat (2) tick();
    bus.job_v = 1'b1;
    bus.job_blocks = 8'd5;
    repeat (10) tick();
    chk("bp_res_v", 64'(bus.res_v), 64'd1);
    chk("bp_res_blk", 64'(bus.res_blk), 64'd1);
    chk("bp_job_ready", 64'(bus.job_ready), 64'd0);
    chk("bp_no_ack", 64'(ack_cnt[0] - ack_base[0]), 64'd0);
    bus.job_v = 1'b0;
    bus.res_yumi = 1'b1;
    wait_idle("bp_idle", 20);

    // Reset mid-job after two results consumed, then a fresh job.
    for (int c = 0; c < NC; c++) lat[c] = 2;
    base_r = res_log.size();
    start_job(4);
    begin
      int k = 0;
      while (res_log.size() - base_r < 2 && k < 40) begin
        tick();
        k++;
      end
    end
    chk("mid_two_consumed", 64'(res_log.size() - base_r >= 2), 64'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    chk("mid_rst_core_v", 64'(bus.core_v), 64'd0);
    chk("mid_rst_res_v", 64'(bus.res_v), 64'd0);
    chk("mid_rst_job_ready", 64'(bus.job_ready), 64'd1);
`ifdef KDA_SCHED_PERF_EN
    chk("mid_rst_busy_cycles", 64'(busy_cycles), 64'd0);
`endif
    tick();
    reset_n = 1'b1;
    tick();
    base_r = res_log.size();
    start_job(2);
    wait_idle("post_rst_idle", 30);
    chk("post_rst_cnt", 64'(res_log.size() - base_r), 64'd2);
    chk("post_rst_blk2", 64'(res_log[$].blk), 64'd2);
    chk("post_rst_core2", 64'(res_log[$].core), 64'd1);
    chk("post_rst_last", 64'(res_log[$].last), 64'd1);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
